// File: rtl/reset_sequencer.sv
// Ordered reset release: holds all stages for HOLD_CYCLES, then frees one stage every GAP_CYCLES, then enables.
// Done/en_out rise HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES + 1 edges after rst/sw_req drop; no backpressure, sw_req/rst restart at any time.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  en_out,
  output logic                  done,
  output logic [1:0]            state_o
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]     IDX_FIRST = (NUM_STAGES > 1) ? IDX_W'(1) : '0;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]     idx;

  assign state_o = state;

  always_ff @(posedge clk) begin
    // A software request restarts from any state; in ASSERT this just reloads the hold count.
    if (rst || sw_req) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      en_out  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            idx     <= IDX_FIRST;
            rst_out <= rst_out << 1;
            state   <= (NUM_STAGES == 1) ? ST_SETTLE : ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            // Stages still in reset are always the upper bits, so a shift frees the next index.
            rst_out <= rst_out << 1;
            if (idx == IDX_LAST) begin
              state <= ST_SETTLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt    <= '0;
          state  <= ST_RUN;
          en_out <= 1'b1;
          done   <= 1'b1;
        end
        default: begin
          cnt     <= '0;
          rst_out <= '0;
          en_out  <= 1'b1;
          done    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table through a scoreboard on the default instance,
// plus hand sequences for asynchronous-looking rst and the single-stage minimum configuration.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_req = 1'b0;
  logic [3:0] rst_out;
  logic       en_out;
  logic       done;
  logic [1:0] state_o;

  logic       rst_b = 1'b1;
  logic       sw_b = 1'b0;
  logic [0:0] rst_out_b;
  logic       en_b;
  logic       done_b;
  logic [1:0] state_b;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk(clk), .rst(rst), .sw_req(sw_req),
    .rst_out(rst_out), .en_out(en_out), .done(done), .state_o(state_o)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst_b), .sw_req(sw_b),
    .rst_out(rst_out_b), .en_out(en_b), .done(done_b), .state_o(state_b)
  );

  localparam logic [1:0] SA = 2'd0, SR = 2'd1, SS = 2'd2, SU = 2'd3;

  typedef struct {
    logic       r;
    logic       sw;
    int         n;
    logic [3:0] ro;
    logic       en;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic [3:0] ro;
    logic       en;
    logic [1:0] st;
    int         id;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic sw, input int n,
                     input logic [3:0] ro, input logic en, input logic [1:0] st);
    vec_t v;
    v.r = r; v.sw = sw; v.n = n; v.ro = ro; v.en = en; v.st = st;
    vt.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    exp_t e;

    // Power-up sequence: edges counted from first edge with rst low.
    add(1, 0, 3,  4'hF, 0, SA);
    add(0, 0, 15, 4'hF, 0, SA);
    add(0, 0, 1,  4'hE, 0, SR);
    add(0, 0, 3,  4'hE, 0, SR);
    add(0, 0, 1,  4'hC, 0, SR);
    add(0, 0, 4,  4'h8, 0, SR);
    add(0, 0, 4,  4'h0, 0, SS);
    add(0, 0, 1,  4'h0, 1, SU);
    add(0, 0, 5,  4'h0, 1, SU);
    // One-cycle request in RUN.
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 15, 4'hF, 0, SA);
    add(0, 0, 1,  4'hE, 0, SR);
    add(0, 0, 12, 4'h0, 0, SS);
    add(0, 0, 1,  4'h0, 1, SU);
    // Request at edge 22, mid-release.
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 21, 4'hC, 0, SR);
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 16, 4'hE, 0, SR);
    add(0, 0, 13, 4'h0, 1, SU);
    // Request during SETTLE, then hold extension at edge 10.
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 28, 4'h0, 0, SS);
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 9,  4'hF, 0, SA);
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 15, 4'hF, 0, SA);
    add(0, 0, 1,  4'hE, 0, SR);
    // Held request parks in ASSERT.
    add(0, 1, 40, 4'hF, 0, SA);
    add(0, 0, 16, 4'hE, 0, SR);
    add(0, 0, 13, 4'h0, 1, SU);
    // Request coinciding with the hold and gap terminal counts.
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 15, 4'hF, 0, SA);
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 16, 4'hE, 0, SR);
    add(0, 0, 3,  4'hE, 0, SR);
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 29, 4'h0, 1, SU);
    // rst pulse at edge 25, and rst together with sw_req.
    add(0, 1, 1,  4'hF, 0, SA);
    add(0, 0, 24, 4'h8, 0, SR);
    add(1, 0, 1,  4'hF, 0, SA);
    add(0, 0, 15, 4'hF, 0, SA);
    add(0, 0, 1,  4'hE, 0, SR);
    add(0, 0, 13, 4'h0, 1, SU);
    add(1, 1, 1,  4'hF, 0, SA);
    add(0, 0, 29, 4'h0, 1, SU);

    foreach (vt[i]) begin
      @(negedge clk);
      rst    = vt[i].r;
      sw_req = vt[i].sw;
      e.ro = vt[i].ro; e.en = vt[i].en; e.st = vt[i].st; e.id = i;
      sb.push_back(e);
      repeat (vt[i].n) @(posedge clk);
      #1;
      e = sb.pop_front();
      check("rst_out", e.id, 32'(rst_out), 32'(e.ro));
      check("en_out",  e.id, 32'(en_out),  32'(e.en));
      check("done",    e.id, 32'(done),    32'(e.en));
      check("state_o", e.id, 32'(state_o), 32'(e.st));
    end

    // rst raised between edges must not disturb outputs until the next edge.
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("sync_rst_out", 1000, 32'(rst_out), 32'h0);
    check("sync_done",    1000, 32'(done),    32'h1);
    @(posedge clk);
    #1;
    check("sync_rst_out", 1001, 32'(rst_out), 32'hF);
    check("sync_done",    1001, 32'(done),    32'h0);
    check("sync_state",   1001, 32'(state_o), 32'(SA));
    @(negedge clk);
    rst = 1'b0;

    // Single-stage, minimum timing instance.
    check("n1_rst_out", 2000, 32'(rst_out_b), 32'h1);
    check("n1_state",   2000, 32'(state_b),   32'(SA));
    check("n1_done",    2000, 32'(done_b),    32'h0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("n1_rst_out", 2001, 32'(rst_out_b), 32'h0);
    check("n1_state",   2001, 32'(state_b),   32'(SS));
    check("n1_done",    2001, 32'(done_b),    32'h0);
    @(posedge clk); #1;
    check("n1_state",   2002, 32'(state_b),   32'(SU));
    check("n1_done",    2002, 32'(done_b),    32'h1);
    check("n1_en_out",  2002, 32'(en_b),      32'h1);
    @(negedge clk);
    sw_b = 1'b1;
    @(posedge clk); #1;
    check("n1_rst_out", 2003, 32'(rst_out_b), 32'h1);
    check("n1_state",   2003, 32'(state_b),   32'(SA));
    check("n1_done",    2003, 32'(done_b),    32'h0);
    @(negedge clk);
    sw_b = 1'b0;
    @(posedge clk); #1;
    check("n1_state",   2004, 32'(state_b),   32'(SS));
    check("n1_rst_out", 2004, 32'(rst_out_b), 32'h0);
    @(posedge clk); #1;
    check("n1_state",   2005, 32'(state_b),   32'(SU));
    check("n1_done",    2005, 32'(done_b),    32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of ordered reset outputs; legal range 1-16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted before the first release; legal range 1 to 2^CNT_WIDTH-1.
REQ-003 SHALL have parameter GAP_CYCLES, default 4: cycles between successive stage releases; legal range 1 to 2^CNT_WIDTH-1.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: width of the internal cycle counter.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port sw_req, input, 1: software re-reset request, level-sampled each cycle.
REQ-008 SHALL have port rst_out, output, NUM_STAGES: per-stage active-high reset; drives the rst of downstream async-reset registers.
REQ-009 SHALL have port en_out, output, 1: register-enable for downstream state; high only when every stage is released.
REQ-010 SHALL have port done, output, 1: sequence complete; equal to en_out.
REQ-011 SHALL have port state_o, output, 2: current FSM state encoding, for debug.

Function
REQ-012 SHALL implement FSM states ASSERT=0, RELEASE=1, SETTLE=2, RUN=3; all outputs SHALL be registered.
REQ-013 ASSERT: rst_out all ones, en_out=0; cnt increments each cycle; at the edge where cnt==HOLD_CYCLES-1: cnt<=0, idx<=1, rst_out[0]<=0, next RELEASE (SETTLE if NUM_STAGES==1).
REQ-014 RELEASE: cnt increments; at the edge where cnt==GAP_CYCLES-1: rst_out[idx]<=0, cnt<=0, idx<=idx+1; when idx==NUM_STAGES-1 the next state SHALL be SETTLE.
REQ-015 Stage release order SHALL be strictly ascending index; a released stage SHALL never re-assert except via REQ-018/REQ-019.
REQ-016 SETTLE SHALL last exactly one cycle, then RUN with en_out<=1 and done<=1.
REQ-017 RUN: rst_out all zero, en_out=done=1, counter held at 0.
REQ-018 sw_req=1 in RUN, RELEASE or SETTLE: next edge SHALL enter ASSERT with rst_out all ones, en_out=done=0, cnt=0, idx=0.
REQ-019 sw_req=1 in ASSERT: cnt SHALL reload to 0, extending the hold; a held-high sw_req keeps the block in ASSERT indefinitely.
REQ-020 sw_req SHALL take priority over the counter-terminal transition in the same cycle.
REQ-021 cnt and idx SHALL never exceed HOLD_CYCLES-1/GAP_CYCLES-1 and NUM_STAGES-1 respectively; no wrap-around is reachable.
REQ-022 Latency from first edge with rst low and sw_req low to done high SHALL be HOLD_CYCLES + (NUM_STAGES-1)*GAP_CYCLES + 1 cycles.

Reset
REQ-023 rst=1 at a rising edge SHALL force state=ASSERT, cnt=0, idx=0, rst_out all ones, en_out=0, done=0, regardless of state or sw_req.
REQ-024 rst asserted mid-sequence SHALL restart the full sequence from ASSERT once deasserted; no partially-released stage survives.
REQ-025 rst SHALL NOT act asynchronously; outputs change only on clk edges.

Verification (defaults N=4, HOLD=16, GAP=4; edge 1 = first edge with rst low)
REQ-026 Power-up: rst high 3 cycles, then low -> rst_out=4'b1111 through edge 15; 4'b1110 after edge 16; 4'b1100 after 20; 4'b1000 after 24; 4'b0000 after 28; done=en_out=1 after edge 29.
REQ-027 sw_req pulse one cycle in RUN -> rst_out=4'b1111, done=0 after next edge; rst_out[0] falls 16 edges later; done after 29 further edges.
REQ-028 sw_req pulsed at edge 22 (RELEASE, rst_out=4'b1100) -> rst_out=4'b1111 after edge 22; full 29-edge sequence restarts.
REQ-029 sw_req high at edge 10 in ASSERT -> rst_out[0] falls at edge 26 instead of 16.
REQ-030 rst pulse at edge 25 -> all outputs at reset values after edge 25; sequence repeats relative to rst deassertion.
REQ-031 NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> rst_out falls after edge 1; done after edge 2; state_o traces 0,2,3.
